// File: rtl/ste_rms_mc.sv
// Time-multiplexed per-channel sliding-window mean-square / RMS engine.
// States: IDLE accept | SQ square+read | ACC window update | MEAN shift | ROOT bit-serial sqrt | OUT strobe.
module ste_rms_mc #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 8,
  parameter int NUM_CH   = 4,
  parameter int SIGNED   = 0,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic [DATA_W-1:0]   din_i,
  input  logic [CH_W-1:0]     din_ch_i,
  input  logic                din_mode_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  output logic [2*DATA_W-1:0] dout_o,
  output logic [CH_W-1:0]     dout_ch_o,
  output logic                dout_valid_o
);

  localparam int DEPTH  = 1 << WIN_LOG2;
  localparam int SQ_W   = 2 * DATA_W;
  localparam int SUM_W  = SQ_W + WIN_LOG2;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ADDR_W = CH_W + WIN_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_ACC, S_MEAN, S_ROOT, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                mode_q, mode_d;
  logic [SQ_W-1:0]     sq_q, sq_d;
  logic [SQ_W-1:0]     old_q;
  logic [SQ_W-1:0]     mean_q, mean_d;
  logic [DATA_W-1:0]   root_q, root_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SQ_W-1:0]     dout_q, dout_d;
  logic [CH_W-1:0]     dout_ch_q, dout_ch_d;
  logic [SUM_W-1:0]    sum_q [NUM_CH];
  logic [SUM_W-1:0]    sum_d [NUM_CH];
  logic [WIN_LOG2-1:0] ptr_q [NUM_CH];
  logic [WIN_LOG2-1:0] ptr_d [NUM_CH];
  logic                full_q [NUM_CH];
  logic                full_d [NUM_CH];
  logic [SQ_W-1:0]     mem_q [NUM_CH*DEPTH];

  logic                ch_ok;
  logic [CH_W-1:0]     ch_idx;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   mag;
  logic [SUM_W-1:0]    new_sum;
  logic [SQ_W-1:0]     mean_w;
  logic [DATA_W-1:0]   trial;
  logic [SQ_W-1:0]     trial_sq;
  logic [DATA_W-1:0]   root_nx;
  logic                mem_we;

  // Out-of-range ids are steered to channel 0 for indexing but never update it.
  assign ch_ok    = (int'(ch_q) < NUM_CH);
  assign ch_idx   = ch_ok ? ch_q : '0;
  assign addr     = {ch_idx, ptr_q[ch_idx]};
  assign mag      = (SIGNED != 0 && din_q[DATA_W-1]) ? (~din_q + DATA_W'(1)) : din_q;
  assign new_sum  = sum_q[ch_idx] + SUM_W'(sq_q) - (full_q[ch_idx] ? SUM_W'(old_q) : '0);
  assign mean_w   = SQ_W'(sum_q[ch_idx] >> WIN_LOG2);
  assign trial    = root_q | (DATA_W'(1) << bit_q);
  assign trial_sq = SQ_W'(trial) * SQ_W'(trial);
  assign root_nx  = (trial_sq <= mean_q) ? trial : root_q;

  assign din_ready_o  = (state_q == S_IDLE) && !clr_i;
  assign dout_valid_o = (state_q == S_OUT);
  assign dout_o       = dout_q;
  assign dout_ch_o    = dout_ch_q;

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    ch_d      = ch_q;
    mode_d    = mode_q;
    sq_d      = sq_q;
    mean_d    = mean_q;
    root_d    = root_q;
    bit_d     = bit_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    sum_d     = sum_q;
    ptr_d     = ptr_q;
    full_d    = full_q;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid_i) begin
          din_d   = din_i;
          ch_d    = din_ch_i;
          mode_d  = din_mode_i;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        sq_d    = SQ_W'(mag) * SQ_W'(mag);
        state_d = ch_ok ? S_ACC : S_IDLE;
      end
      S_ACC: begin
        sum_d[ch_idx] = new_sum;
        ptr_d[ch_idx] = ptr_q[ch_idx] + WIN_LOG2'(1);
        if (&ptr_q[ch_idx]) full_d[ch_idx] = 1'b1;
        mem_we  = 1'b1;
        state_d = S_MEAN;
      end
      S_MEAN: begin
        mean_d = mean_w;
        if (!full_q[ch_idx]) begin
          state_d = S_IDLE;
        end else if (mode_q) begin
          dout_d    = mean_w;
          dout_ch_d = ch_q;
          state_d   = S_OUT;
        end else begin
          root_d  = '0;
          bit_d   = BIT_W'(DATA_W - 1);
          state_d = S_ROOT;
        end
      end
      S_ROOT: begin
        root_d = root_nx;
        if (bit_q == '0) begin
          dout_d    = SQ_W'(root_nx);
          dout_ch_d = ch_q;
          state_d   = S_OUT;
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Clear dominates everything except the result registers.
    if (clr_i) begin
      state_d = S_IDLE;
      mem_we  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_d[i]  = '0;
        ptr_d[i]  = '0;
        full_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      din_q     <= '0;
      ch_q      <= '0;
      mode_q    <= 1'b0;
      sq_q      <= '0;
      mean_q    <= '0;
      root_q    <= '0;
      bit_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i]  <= '0;
        ptr_q[i]  <= '0;
        full_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      ch_q      <= ch_d;
      mode_q    <= mode_d;
      sq_q      <= sq_d;
      mean_q    <= mean_d;
      root_q    <= root_d;
      bit_q     <= bit_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      sum_q     <= sum_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
    end
  end

  // Window buffer is never cleared; the full flags decide when old entries count.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr] <= sq_q;
    if (state_q == S_SQ) old_q <= mem_q[addr];
  end

endmodule

// File: tb/tb_ste_rms_mc.sv
// Directed bench for ste_rms_mc: unsigned and signed instances share one stimulus stream.
// Three channels give a 2-bit id so that the unused id 3 can be driven.
module tb_ste_rms_mc;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [15:0] din;
  logic [1:0]  din_ch;
  logic        din_mode, din_valid;
  logic        ready, ready_s;
  logic [31:0] dout, dout_s;
  logic [1:0]  dout_ch, dout_ch_s;
  logic        dout_valid, dout_valid_s;

  int n_chk = 0;
  int n_bad = 0;
  int nv, nv_s, lat, k_rdy, cnt;
  logic [31:0] val, val_s;
  logic [1:0]  vch, vch_s;

  always #5 clk = ~clk;

  ste_rms_mc #(.DATA_W(16), .WIN_LOG2(2), .NUM_CH(3), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .clr_i(clr), .din_i(din), .din_ch_i(din_ch),
    .din_mode_i(din_mode), .din_valid_i(din_valid), .din_ready_o(ready),
    .dout_o(dout), .dout_ch_o(dout_ch), .dout_valid_o(dout_valid));

  ste_rms_mc #(.DATA_W(16), .WIN_LOG2(2), .NUM_CH(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .clr_i(clr), .din_i(din), .din_ch_i(din_ch),
    .din_mode_i(din_mode), .din_valid_i(din_valid), .din_ready_o(ready_s),
    .dout_o(dout_s), .dout_ch_o(dout_ch_s), .dout_valid_o(dout_valid_s));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] ch, input logic [15:0] d, input logic m);
    din = d; din_ch = ch; din_mode = m; din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  // k counts edges after acceptance; valid seen at k=lat, ready back at k=k_rdy.
  task automatic send(input logic [1:0] ch, input logic [15:0] d, input logic m);
    launch(ch, d, m);
    nv = 0; nv_s = 0; lat = -1; k_rdy = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dout_valid) begin nv++; lat = k; val = dout; vch = dout_ch; end
      if (dout_valid_s) begin nv_s++; val_s = dout_s; vch_s = dout_ch_s; end
      if (ready) begin k_rdy = k; break; end
    end
    if (k_rdy < 0) chk("ready timeout", 0, 1);
  endtask

  task automatic smp(input logic [1:0] ch, input logic [15:0] d, input logic m,
                     input bit exp_out, input logic [31:0] exp, input bit on_s, input string tag);
    send(ch, d, m);
    if (on_s) begin
      chk({tag, " nv_s"}, nv_s, exp_out);
      if (exp_out) begin
        chk({tag, " val_s"}, val_s, exp);
        chk({tag, " ch_s"}, vch_s, ch);
      end
    end else begin
      chk({tag, " nv"}, nv, exp_out);
      if (exp_out) begin
        chk({tag, " val"}, val, exp);
        chk({tag, " ch"}, vch, ch);
      end
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; din = '0; din_ch = '0; din_mode = 1'b0; din_valid = 1'b0;
    #1;
    chk("rst dout", dout, 0);
    chk("rst dout_ch", dout_ch, 0);
    chk("rst valid", dout_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("ready after rst", ready, 1);
    chk("ready_s after rst", ready_s, 1);
    @(negedge clk);

    // warm-up and RMS latency
    smp(0, 3, 0, 0, 0, 0, "warm1");
    chk("warm1 k_rdy", k_rdy, 3);
    smp(0, 3, 0, 0, 0, 0, "warm2");
    smp(0, 3, 0, 0, 0, 0, "warm3");
    smp(0, 3, 0, 1, 3, 0, "rms3");
    chk("rms lat", lat, 19);
    chk("rms k_rdy", k_rdy, 20);

    // sliding window
    smp(0, 5, 0, 1, 3, 0, "slide rms13");
    smp(0, 5, 1, 1, 17, 0, "slide ms17");
    chk("ms lat", lat, 3);
    chk("ms k_rdy", k_rdy, 4);
    chk("hold dout", dout, 17);

    // channel independence; ch0 window walks 5,5,3,3 -> all 7s
    smp(1, 100, 0, 0, 0, 0, "ch1 a");
    smp(0, 7, 0, 1, 5, 0, "ch0 a");
    smp(1, 100, 0, 0, 0, 0, "ch1 b");
    smp(0, 7, 0, 1, 6, 0, "ch0 b");
    smp(1, 100, 0, 0, 0, 0, "ch1 c");
    smp(0, 7, 0, 1, 6, 0, "ch0 c");
    smp(1, 100, 0, 1, 100, 0, "ch1 d");
    smp(0, 7, 0, 1, 7, 0, "ch0 d");
    smp(3, 16'h1234, 1, 0, 0, 0, "bad id");
    chk("bad id k_rdy", k_rdy, 1);
    smp(0, 7, 0, 1, 7, 0, "ch0 after bad id");
    smp(1, 100, 0, 1, 100, 0, "ch1 after bad id");

    // signed extremes on the signed instance
    pulse_clr();
    smp(0, 16'hFFFC, 0, 0, 0, 1, "neg4 a");
    smp(0, 16'hFFFC, 0, 0, 0, 1, "neg4 b");
    smp(0, 16'hFFFC, 0, 0, 0, 1, "neg4 c");
    smp(0, 16'hFFFC, 0, 1, 4, 1, "neg4 rms");
    for (int i = 0; i < 3; i++) smp(1, 16'h8000, 1, 0, 0, 1, "min warm");
    smp(1, 16'h8000, 1, 1, 32'h4000_0000, 1, "min ms");
    smp(1, 16'h8000, 0, 1, 32768, 1, "min rms");

    // unsigned full scale
    pulse_clr();
    for (int i = 0; i < 3; i++) smp(0, 16'hFFFF, 1, 0, 0, 0, "ffff warm");
    smp(0, 16'hFFFF, 1, 1, 32'hFFFE_0001, 0, "ffff ms");
    smp(0, 16'hFFFF, 0, 1, 32'h0000_FFFF, 0, "ffff rms");

    // clear during ROOT drops the result
    launch(0, 16'hFFFF, 0);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    #1 chk("ready low under clr", ready, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("ready after clr", ready, 1);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (dout_valid) cnt++;
      @(negedge clk);
    end
    chk("no valid after clr", cnt, 0);
    chk("dout kept over clr", dout, 32'h0000_FFFF);
    // clear beats a same-cycle valid sample
    din = 9; din_ch = 0; din_mode = 1'b1; din_valid = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("clr beats valid", ready, 1);
    smp(0, 2, 0, 0, 0, 0, "post clr 1");
    smp(0, 2, 0, 0, 0, 0, "post clr 2");
    smp(0, 2, 0, 0, 0, 0, "post clr 3");
    smp(0, 2, 0, 1, 2, 0, "post clr 4");

    // reset mid-ROOT
    for (int i = 0; i < 3; i++) smp(1, 9, 1, 0, 0, 0, "ch1 9 warm");
    smp(1, 9, 1, 1, 81, 0, "ch1 9 ms");
    launch(1, 9, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1 chk("rst mid dout", dout, 0);
    chk("rst mid ch", dout_ch, 0);
    chk("rst mid valid", dout_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("ready after rst2", ready, 1);
    @(negedge clk);

    // boundaries: mean 15 -> 3, all-zero window -> 0
    smp(0, 5, 0, 0, 0, 0, "m15 a");
    smp(0, 5, 0, 0, 0, 0, "m15 b");
    smp(0, 3, 0, 0, 0, 0, "m15 c");
    smp(0, 1, 0, 1, 3, 0, "m15 rms");
    smp(0, 1, 1, 1, 9, 0, "m9 ms");
    for (int i = 0; i < 3; i++) smp(1, 0, 0, 0, 0, 0, "zero warm");
    smp(1, 0, 0, 1, 0, 0, "zero rms");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
